// File: rtl/ula_pkg.sv
// ============================================================================
// ula_pkg : opcodes, FSM states and flag indices for ula_sequencial_nbits
// Rev 1.0
// ============================================================================
`default_nettype none

package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OV    = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_W     = 4;

endpackage

`default_nettype wire

// File: rtl/multiplicador_seq.sv
// ============================================================================
// multiplicador_seq : unsigned shift-add multiplier, one multiplier bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module multiplicador_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_busy;

  // Bit 0 is folded into the load edge so the product is final after
  // WIDTH-1 further edges; done then lets the owner capture it on the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (load) begin
      r_busy   <= 1'b1;
      r_count  <= C_LAST;
      r_mcand  <= {{WIDTH{1'b0}}, multiplicand} << 1;
      r_mplier <= multiplier >> 1;
      r_prod   <= multiplier[0] ? {{WIDTH{1'b0}}, multiplicand} : '0;
    end else if (r_busy) begin
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CW'(1);
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_count == '0);
  assign product = r_prod;

endmodule

`default_nettype wire

// File: rtl/ula_sequencial_nbits.sv
// ============================================================================
// ula_sequencial_nbits : registered N-bit ALU with accumulator and seq. multiply
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_sequencial_nbits
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ov,
  output logic             flag_neg
);

  localparam int SHW = $clog2(WIDTH);

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_result;
  logic [FLAG_W-1:0]    r_flags;
  logic                 r_done;

  logic                 w_accept, w_load, w_mul_fin;
  logic                 w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_op_a, w_res, w_mul_lo;
  logic                 w_carry, w_ov;
  logic [WIDTH:0]       w_sum, w_diff, w_shl, w_shr;
  logic [SHW-1:0]       w_amt;

  // result doubles as the accumulator
  assign w_op_a = use_acc ? r_result : a;
  assign w_amt  = b[SHW-1:0];
  assign w_sum  = {1'b0, w_op_a} + {1'b0, b};
  assign w_diff = {1'b0, w_op_a} - {1'b0, b};
  assign w_shl  = {1'b0, w_op_a} << w_amt;
  assign w_shr  = {w_op_a, 1'b0} >> w_amt;
  assign w_mul_lo = w_product[WIDTH-1:0];

  multiplicador_seq #(.WIDTH(WIDTH)) u_mult (
    .clk          (clk),
    .rst          (rst),
    .load         (w_load),
    .multiplicand (w_op_a),
    .multiplier   (b),
    .busy         (w_mul_busy),
    .done         (w_mul_done),
    .product      (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_mul_fin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            w_load       = 1'b1;
            w_state_next = S_MUL;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (w_mul_done) begin
          w_mul_fin    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shifts keep the last bit shifted out in the extra position of w_shl/w_shr.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ov    = 1'b0;
    case (op)
      OP_ADD: begin
        {w_carry, w_res} = w_sum;
        w_ov = (w_op_a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      OP_SUB: begin
        {w_carry, w_res} = w_diff;
        w_ov = (w_op_a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      OP_AND:  w_res = w_op_a & b;
      OP_OR:   w_res = w_op_a | b;
      OP_XOR:  w_res = w_op_a ^ b;
      OP_SHL:  {w_carry, w_res} = w_shl;
      OP_SHR:  {w_res, w_carry} = w_shr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_accept | w_mul_fin;
      if (w_accept) begin
        r_result            <= w_res;
        r_flags[FLAG_ZERO]  <= (w_res == '0);
        r_flags[FLAG_CARRY] <= w_carry;
        r_flags[FLAG_OV]    <= w_ov;
        r_flags[FLAG_NEG]   <= w_res[WIDTH-1];
      end else if (w_mul_fin) begin
        r_result            <= w_mul_lo;
        r_flags[FLAG_ZERO]  <= (w_mul_lo == '0);
        r_flags[FLAG_CARRY] <= 1'b0;
        r_flags[FLAG_OV]    <= (w_product[2*WIDTH-1:WIDTH] != '0);
        r_flags[FLAG_NEG]   <= w_mul_lo[WIDTH-1];
      end
    end
  end

  assign busy       = w_mul_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign flag_zero  = r_flags[FLAG_ZERO];
  assign flag_carry = r_flags[FLAG_CARRY];
  assign flag_ov    = r_flags[FLAG_OV];
  assign flag_neg   = r_flags[FLAG_NEG];

endmodule

`default_nettype wire

// File: tb/tb_ula_sequencial_nbits.sv
// ============================================================================
// tb_ula_sequencial_nbits : directed self-checking bench, WIDTH = 8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ula_sequencial_nbits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic       use_acc = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, flag_zero, flag_carry, flag_ov, flag_neg;
  logic [7:0] result;
  logic [3:0] fl;

  int checks = 0;
  int errors = 0;

  assign fl = {flag_neg, flag_ov, flag_carry, flag_zero};

  ula_sequencial_nbits #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_acc(use_acc),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ov(flag_ov),
    .flag_neg(flag_neg)
  );

  always #5 clk = ~clk;

  // Drives one start cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input logic acc);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb; use_acc = acc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({result, fl, busy, done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got res=%h fl=%b busy=%b done=%b exp all 0", result, fl, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    issue(3'b000, 8'h7F, 8'h01, 1'b0);
    checks++;
    if ({result, fl, done} !== {8'h80, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL add_ov: got res=%h fl=%b done=%b exp 80 1100 1", result, fl, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse: got done=%b exp 0", done);
    end
    issue(3'b000, 8'hFF, 8'h01, 1'b0);
    checks++;
    if ({result, fl} !== {8'h00, 4'b0011}) begin
      errors++;
      $display("FAIL add_carry: got res=%h fl=%b exp 00 0011", result, fl);
    end
  endtask

  task automatic test_sub_acc;
    issue(3'b001, 8'h05, 8'h07, 1'b0);
    checks++;
    if ({result, fl} !== {8'hFE, 4'b1010}) begin
      errors++;
      $display("FAIL sub_borrow: got res=%h fl=%b exp FE 1010", result, fl);
    end
    issue(3'b000, 8'h55, 8'h02, 1'b1);
    checks++;
    if ({result, fl} !== {8'h00, 4'b0011}) begin
      errors++;
      $display("FAIL acc_add: got res=%h fl=%b exp 00 0011", result, fl);
    end
  endtask

  task automatic test_shift;
    issue(3'b101, 8'h81, 8'h01, 1'b0);
    checks++;
    if ({result, fl} !== {8'h02, 4'b0010}) begin
      errors++;
      $display("FAIL shl_1: got res=%h fl=%b exp 02 0010", result, fl);
    end
    issue(3'b110, 8'h81, 8'h00, 1'b0);
    checks++;
    if ({result, fl} !== {8'h81, 4'b1000}) begin
      errors++;
      $display("FAIL shr_0: got res=%h fl=%b exp 81 1000", result, fl);
    end
    issue(3'b110, 8'h81, 8'h07, 1'b0);
    checks++;
    if ({result, fl} !== {8'h01, 4'b0000}) begin
      errors++;
      $display("FAIL shr_7: got res=%h fl=%b exp 01 0000", result, fl);
    end
  endtask

  task automatic test_logic;
    issue(3'b010, 8'hF0, 8'h3C, 1'b0);
    checks++;
    if ({result, fl} !== {8'h30, 4'b0000}) begin
      errors++;
      $display("FAIL and: got res=%h fl=%b exp 30 0000", result, fl);
    end
    issue(3'b011, 8'hF0, 8'h0C, 1'b0);
    checks++;
    if ({result, fl} !== {8'hFC, 4'b1000}) begin
      errors++;
      $display("FAIL or: got res=%h fl=%b exp FC 1000", result, fl);
    end
    issue(3'b100, 8'hA5, 8'hA5, 1'b0);
    checks++;
    if ({result, fl} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL xor: got res=%h fl=%b exp 00 0001", result, fl);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01; use_acc = 1'b0;
    @(negedge clk);
    use_acc = 1'b1; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({result, done} !== {8'h05, 1'b1}) begin
      errors++;
      $display("FAIL back_to_back: got res=%h done=%b exp 05 1", result, done);
    end
    use_acc = 1'b0;
  endtask

  task automatic test_mul;
    int n, dn;
    issue(3'b111, 8'h10, 8'h10, 1'b0);
    n = 0; dn = 0;
    while (busy && n < 20) begin
      n++;
      if (done) dn++;
      @(negedge clk);
    end
    checks++;
    if (n != 8 || dn != 0) begin
      errors++;
      $display("FAIL mul_busy_len: got busy=%0d cycles done_in_busy=%0d exp 8 0", n, dn);
    end
    checks++;
    if ({result, fl, done} !== {8'h00, 4'b0101, 1'b1}) begin
      errors++;
      $display("FAIL mul_ov: got res=%h fl=%b done=%b exp 00 0101 1", result, fl, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse: got done=%b exp 0", done);
    end
    issue(3'b111, 8'h0C, 8'h0B, 1'b0);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    checks++;
    if ({result, fl, done} !== {8'h84, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL mul_84: got res=%h fl=%b done=%b exp 84 1000 1", result, fl, done);
    end
  endtask

  task automatic test_start_during_mul;
    int n;
    issue(3'b111, 8'h03, 8'h05, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    checks++;
    if ({result, fl, done} !== {8'h0F, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL mul_ignore_start: got res=%h fl=%b done=%b exp 0F 0000 1", result, fl, done);
    end
    @(negedge clk);
    checks++;
    if ({result, done} !== {8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL mul_no_queue: got res=%h done=%b exp 0F 0", result, done);
    end
  endtask

  task automatic test_start_held;
    int n;
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 8'h02; b = 8'h03; use_acc = 1'b0;
    @(negedge clk);
    op = 3'b000; a = 8'h20; b = 8'h01;
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    checks++;
    if ({result, done, busy} !== {8'h06, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL held_mul: got res=%h done=%b busy=%b exp 06 1 0", result, done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({result, done} !== {8'h21, 1'b1}) begin
      errors++;
      $display("FAIL held_next_op: got res=%h done=%b exp 21 1", result, done);
    end
  endtask

  task automatic test_reset_mid_mul;
    issue(3'b111, 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({result, fl, busy, done} !== 14'd0) begin
      errors++;
      $display("FAIL rst_async: got res=%h fl=%b busy=%b done=%b exp all 0", result, fl, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({result, fl, busy, done} !== 14'd0) begin
        errors++;
        $display("FAIL rst_hold%0d: got res=%h fl=%b busy=%b done=%b exp all 0", i, result, fl, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_acc();
    test_shift();
    test_logic();
    test_back_to_back();
    test_mul();
    test_start_during_mul();
    test_start_held();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ula_sequencial_nbits.md
Name: ula_sequencial_nbits

Overview:
- Registered, parametrised-width successor of the 4-bit combinational ULA.
- Operations:
  - Single-cycle: add, sub, AND, OR, XOR, shift-left, shift-right.
  - Multi-cycle: shift-add multiply, run under a start/busy/done handshake.
- Holds an internal accumulator that can replace operand A, which allows chained computation from switches/buttons.
- Result and flags are registered, ready to drive the 7-seg decoder and LEDs in the board top.

Parameters:
- WIDTH, 8, operand/result/accumulator width in bits (legal ≥ 2).
- SHW, $clog2(WIDTH), shift-amount width, derived, not to be overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request operation; sampled on rising clk edge
- op  input  3  000 add, 001 sub, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- use_acc  input  1  1: operand A = accumulator; 0: operand A = a
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, shift amount = b[SHW-1:0]
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when result/flags update
- result  output  WIDTH  registered result (also the accumulator value)
- flag_zero  output  1  result == 0
- flag_carry  output  1  carry/borrow
- flag_ov  output  1  signed overflow / multiply overflow
- flag_neg  output  1  result[WIDTH-1]

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - result, accumulator and all flags go to 0; done=0, busy=0.
  - Takes effect immediately, including mid-multiply; the partial product is discarded.
- FSM states:
  - IDLE: waits for start. Captures opA (a or acc per use_acc), b and op on the accepting edge.
  - MUL: iterates.
  - No separate DONE state; done is a registered pulse.
- Single-cycle ops (op ≠ 111), start=1 in IDLE at edge T:
  - result, acc and flags are written at edge T.
  - done=1 for the cycle after T; busy stays 0.
  - Back-to-back starts on consecutive cycles are each accepted; done is high continuously in that case.
- MUL, start=1 at edge T:
  - Enter MUL; busy=1 from T through edge T+WIDTH.
  - One multiplier bit is consumed per cycle (WIDTH iterations).
  - At edge T+WIDTH: result = low WIDTH bits of the unsigned 2·WIDTH product; acc and flags are written; state returns to IDLE; busy=0; done=1 for one cycle.
  - Total latency is WIDTH cycles.
- start while busy=1 is ignored, with no queuing. start in the same cycle as completion is also ignored; the new op is accepted on the next edge.
- Operand a/b/use_acc changes during MUL have no effect because operands are latched.
- Arithmetic and flags:
  - add:
    - {carry,result} = opA + b.
    - ov = (opA msb == b msb) && (result msb ≠ opA msb).
  - sub:
    - result = opA − b (mod 2^WIDTH).
    - carry = borrow, i.e. 1 iff opA < b unsigned.
    - ov = (opA msb ≠ b msb) && (result msb ≠ opA msb).
  - AND/OR/XOR: carry=0, ov=0.
  - SHL/SHR:
    - Logical, with zero fill.
    - Amount is b[SHW-1:0]; amount 0 passes opA through.
    - carry = last bit shifted out (0 when amount 0); ov=0.
  - MUL: carry=0; ov=1 iff the upper WIDTH product bits ≠ 0.
  - zero/neg are always derived from the new result.
- Hold: result/flags/acc are unchanged except on completion; they hold indefinitely in IDLE.

Decomposition:
- Package ula_pkg:
  - op-code localparams: OP_ADD … OP_MUL.
  - FSM state encoding: S_IDLE, S_MUL.
  - Flag-vector index constants.
- Sub-module multiplicador_seq (WIDTH):
  - Ports: clk, rst, load, multiplicand, multiplier, busy, done, product[2·WIDTH-1:0].
  - Implements a shift-add with an iteration counter.
  - Instantiated once; the top owns op decode, flag logic, accumulator and done generation.
- Single-cycle ops form a combinational datapath inside the top; no further sub-modules.

Test Plan:
- Reset/hold: assert rst mid-sim with result nonzero → result=0, all flags 0, busy=0, done=0 immediately (before next edge); hold 5 idle cycles → unchanged.
- Add overflow/carry (WIDTH=8): a=0x7F, b=0x01, op=000 → result=0x80, ov=1, neg=1, carry=0, done pulse 1 cycle; then a=0xFF, b=0x01 → result=0x00, carry=1, zero=1, ov=0.
- Sub borrow plus accumulator chain: a=0x05, b=0x07, sub → result=0xFE, carry=1, neg=1; next start use_acc=1, b=0x02, add → result=0x00, carry=1, zero=1.
- Shift boundaries: a=0x81, b=0x01, SHL → 0x02, carry=1; b=0x00, SHR → 0x81, carry=0; b=0x07, SHR → 0x01, carry=0.
- Multiply latency/overflow: a=0x10, b=0x10, MUL → busy high exactly 8 cycles, then result=0x00, ov=1, zero=1, done single pulse; a=0x0C, b=0x0B → result=0x84, ov=0, neg=1.
- Handshake corner cases:
  - start pulsed during MUL (op=add) → ignored; MUL result unaffected.
  - start held high through completion → next op accepted one edge after done.
  - rst asserted at MUL iteration 3 → busy drops at once, no done pulse, result=0.
